// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings {CS_n,RAS_n,CAS_n,WE_n},
// init sequencer states and address-bit conventions.
package sdram_pkg;

   localparam logic [3:0] CMD_NOP       = 4'b0111;
   localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
   localparam logic [3:0] CMD_READ      = 4'b0101;
   localparam logic [3:0] CMD_WRITE     = 4'b0100;
   localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
   localparam logic [3:0] CMD_REFRESH   = 4'b0001;
   localparam logic [3:0] CMD_LMR       = 4'b0000;

   // A10 high during PRECHARGE selects all banks.
   localparam int A10_BIT = 10;

   typedef enum logic [3:0] {
      ST_WAIT_PAA  = 4'd0,
      ST_CKE_ON    = 4'd1,
      ST_PRECH     = 4'd2,
      ST_WAIT_RP   = 4'd3,
      ST_REF       = 4'd4,
      ST_WAIT_RFC  = 4'd5,
      ST_WAIT_MODE = 4'd6,
      ST_LMR       = 4'd7,
      ST_WAIT_MRD  = 4'd8,
      ST_DONE      = 4'd9
   } init_state_t;

endpackage

// File: rtl/sdram_wait_timer.sv
// Loadable down-counter. zero_next is high when the count reaches zero at the
// next edge, so a wait state exits exactly (load_val + 1) cycles after loading.
module sdram_wait_timer #(
   parameter int W = 4
) (
   input  logic         sdram_clk,
   input  logic         sdram_rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero_next
);

   logic [W-1:0] count;

   always_ff @(posedge sdram_clk) begin
      if (sdram_rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - W'(1);
      end
   end

   assign zero_next = (count <= W'(1));

endmodule

// File: rtl/sdram_init_seq.sv
// SDR SDRAM power-up init sequencer: CKE on, PRECHARGE ALL, REF_NUM x AUTO
// REFRESH, LOAD MODE, then a sticky INIT_DONE hands the bus to the controller.
module sdram_init_seq
   import sdram_pkg::*;
#(
   parameter int ADDR_W   = 13,
   parameter int BA_W     = 2,
   parameter int T_RP     = 3,
   parameter int T_RFC    = 9,
   parameter int T_MRD    = 2,
   parameter int REF_NUM  = 8,
   parameter logic [ADDR_W-1:0] MODE_REG = ADDR_W'(13'h0033)
) (
   input  logic              sdram_clk,
   input  logic              sdram_rst,
   input  logic              PAA,
   input  logic              SET_MODE,
   output logic              CKE,
   output logic [3:0]        CMD,
   output logic [ADDR_W-1:0] ADDR,
   output logic [BA_W-1:0]   BA,
   output logic              INIT_DONE,
   output init_state_t       state_dbg
);

   localparam int T_MAX_A = (T_RP > T_RFC) ? T_RP : T_RFC;
   localparam int T_MAX   = (T_MAX_A > T_MRD) ? T_MAX_A : T_MRD;
   localparam int TMR_W   = (T_MAX > 1) ? $clog2(T_MAX) : 1;

   localparam logic [TMR_W-1:0] TMR_RP  = TMR_W'(T_RP - 1);
   localparam logic [TMR_W-1:0] TMR_RFC = TMR_W'(T_RFC - 1);
   localparam logic [TMR_W-1:0] TMR_MRD = TMR_W'(T_MRD - 1);
   localparam logic [8:0]       REF_NUM_W = 9'(REF_NUM);

   init_state_t       state, state_d;
   logic [7:0]        ref_cnt;
   logic              ref_inc;
   logic              tmr_load;
   logic [TMR_W-1:0]  tmr_val;
   logic              tmr_zero_next;
   logic              more_now, more_after_inc;
   init_state_t       mode_state;

   logic              cke_d, done_d;
   logic [3:0]        cmd_d;
   logic [ADDR_W-1:0] addr_d;
   logic [BA_W-1:0]   ba_d;

   sdram_wait_timer #(.W(TMR_W)) u_timer (
      .sdram_clk (sdram_clk),
      .sdram_rst (sdram_rst),
      .load      (tmr_load),
      .load_val  (tmr_val),
      .zero_next (tmr_zero_next)
   );

   // With a 1-cycle timing the issue state skips its wait state, so the
   // refresh-count decision must look at the count after this increment.
   assign more_now       = ({1'b0, ref_cnt} < REF_NUM_W);
   assign more_after_inc = (({1'b0, ref_cnt} + 9'd1) < REF_NUM_W);
   assign mode_state     = SET_MODE ? ST_LMR : ST_WAIT_MODE;
   assign state_dbg      = state;

   always_ff @(posedge sdram_clk) begin
      if (sdram_rst) begin
         state   <= ST_WAIT_PAA;
         ref_cnt <= 8'd0;
      end else begin
         state <= state_d;
         if (ref_inc) ref_cnt <= ref_cnt + 8'd1;
      end
   end

   always_comb begin
      state_d  = state;
      ref_inc  = 1'b0;
      tmr_load = 1'b0;
      tmr_val  = '0;
      cke_d    = CKE;
      cmd_d    = CMD_NOP;
      addr_d   = ADDR;
      ba_d     = BA;
      done_d   = INIT_DONE;
      unique case (state)
         ST_WAIT_PAA: begin
            if (PAA) state_d = ST_CKE_ON;
         end
         ST_CKE_ON: begin
            cke_d   = 1'b1;
            state_d = ST_PRECH;
         end
         ST_PRECH: begin
            cmd_d           = CMD_PRECHARGE;
            addr_d          = '0;
            addr_d[A10_BIT] = 1'b1;
            ba_d            = '0;
            tmr_load        = 1'b1;
            tmr_val         = TMR_RP;
            state_d         = (T_RP == 1) ? ST_REF : ST_WAIT_RP;
         end
         ST_WAIT_RP: begin
            if (tmr_zero_next) state_d = ST_REF;
         end
         ST_REF: begin
            cmd_d    = CMD_REFRESH;
            ref_inc  = 1'b1;
            tmr_load = 1'b1;
            tmr_val  = TMR_RFC;
            if (T_RFC == 1) state_d = more_after_inc ? ST_REF : mode_state;
            else            state_d = ST_WAIT_RFC;
         end
         ST_WAIT_RFC: begin
            if (tmr_zero_next) state_d = more_now ? ST_REF : mode_state;
         end
         ST_WAIT_MODE: begin
            if (SET_MODE) state_d = ST_LMR;
         end
         ST_LMR: begin
            cmd_d    = CMD_LMR;
            addr_d   = MODE_REG;
            ba_d     = '0;
            tmr_load = 1'b1;
            tmr_val  = TMR_MRD;
            state_d  = (T_MRD == 1) ? ST_DONE : ST_WAIT_MRD;
         end
         ST_WAIT_MRD: begin
            if (tmr_zero_next) state_d = ST_DONE;
         end
         ST_DONE: begin
            cke_d  = 1'b1;
            done_d = 1'b1;
         end
         default: state_d = ST_WAIT_PAA;
      endcase
   end

   always_ff @(posedge sdram_clk) begin
      if (sdram_rst) begin
         CKE       <= 1'b0;
         CMD       <= CMD_NOP;
         ADDR      <= '0;
         BA        <= '0;
         INIT_DONE <= 1'b0;
      end else begin
         CKE       <= cke_d;
         CMD       <= cmd_d;
         ADDR      <= addr_d;
         BA        <= ba_d;
         INIT_DONE <= done_d;
      end
   end

endmodule

// File: tb/tb_sdram_init_seq.sv
// Bench for sdram_init_seq: a default-timing instance and an all-1-cycle
// instance, checked every cycle against a command-schedule model.
module tb_sdram_init_seq;
   import sdram_pkg::*;

   localparam int P_RP  [2] = '{3, 1};
   localparam int P_RFC [2] = '{9, 1};
   localparam int P_MRD [2] = '{2, 1};
   localparam int P_NUM [2] = '{8, 2};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_i [2];
   logic        paa_i [2];
   logic        set_i [2];
   logic        cke_o [2];
   logic [3:0]  cmd_o [2];
   logic [12:0] addr_o [2];
   logic [1:0]  ba_o [2];
   logic        done_o [2];
   init_state_t st_dbg [2];

   int e = 0;
   int n_chk = 0;
   int n_fail = 0;

   // Model: PAA acceptance edge, LOAD MODE cycle, reset-this-cycle flag.
   int   m_act [2];
   int   m_k [2];
   int   m_lmr [2];
   int   m_rst [2];
   logic [3:0] prev_cmd_a = CMD_NOP;
   int   ref_seen_a = 0;

   sdram_init_seq dut_a (
      .sdram_clk (clk), .sdram_rst (rst_i[0]), .PAA (paa_i[0]), .SET_MODE (set_i[0]),
      .CKE (cke_o[0]), .CMD (cmd_o[0]), .ADDR (addr_o[0]), .BA (ba_o[0]),
      .INIT_DONE (done_o[0]), .state_dbg (st_dbg[0])
   );

   sdram_init_seq #(.T_RP(1), .T_RFC(1), .T_MRD(1), .REF_NUM(2)) dut_b (
      .sdram_clk (clk), .sdram_rst (rst_i[1]), .PAA (paa_i[1]), .SET_MODE (set_i[1]),
      .CKE (cke_o[1]), .CMD (cmd_o[1]), .ADDR (addr_o[1]), .BA (ba_o[1]),
      .INIT_DONE (done_o[1]), .state_dbg (st_dbg[1])
   );

   task automatic check(input string name, input int idx, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d] cycle %0d: got 0x%0h, expected 0x%0h", name, idx, e, got, exp);
      end
   endtask

   task automatic wait_edge(input int n);
      while (e < n) @(negedge clk);
   endtask

   function automatic int first_ref(input int i);
      return m_k[i] + 2 + P_RP[i];
   endfunction

   function automatic int earliest_lmr(input int i);
      return first_ref(i) + P_NUM[i] * P_RFC[i];
   endfunction

   function automatic logic [3:0] exp_cmd(input int i);
      if (m_act[i] == 0) return CMD_NOP;
      if (e == m_k[i] + 2) return CMD_PRECHARGE;
      if (e >= first_ref(i) && e < earliest_lmr(i) && ((e - first_ref(i)) % P_RFC[i]) == 0)
         return CMD_REFRESH;
      if (m_lmr[i] >= 0 && e == m_lmr[i]) return CMD_LMR;
      return CMD_NOP;
   endfunction

   initial begin
      for (int i = 0; i < 2; i++) begin
         m_act[i] = 0; m_k[i] = 0; m_lmr[i] = -1; m_rst[i] = 0;
      end
   end

   // Model update and every-cycle compare, 1 time unit after each rising edge.
   always begin
      @(posedge clk);
      #1;
      e = e + 1;
      for (int i = 0; i < 2; i++) begin
         logic [3:0] xc;
         if (rst_i[i]) begin
            m_act[i] = 0; m_lmr[i] = -1; m_rst[i] = 1;
         end else begin
            m_rst[i] = 0;
            if (m_act[i] == 0 && paa_i[i]) begin
               m_act[i] = 1; m_k[i] = e;
            end else if (m_act[i] != 0 && m_lmr[i] < 0 && set_i[i] && e + 1 >= earliest_lmr(i)) begin
               m_lmr[i] = e + 1;
            end
         end
         xc = exp_cmd(i);
         check("cmd", i, cmd_o[i], xc);
         check("cke", i, cke_o[i], (m_act[i] != 0 && e >= m_k[i] + 1));
         check("init_done", i, done_o[i], (m_act[i] != 0 && m_lmr[i] >= 0 && e >= m_lmr[i] + P_MRD[i]));
         check("ba", i, ba_o[i], 0);
         if (xc == CMD_PRECHARGE) check("addr_prech", i, addr_o[i], 13'h0400);
         if (xc == CMD_LMR)       check("addr_lmr", i, addr_o[i], 13'h0033);
         if (m_rst[i] != 0)       check("addr_rst", i, addr_o[i], 0);
      end

      check("back_to_back_cmd", 0, (prev_cmd_a != CMD_NOP && cmd_o[0] != CMD_NOP), 0);
      prev_cmd_a = cmd_o[0];
      if (rst_i[0]) ref_seen_a = 0;
      else if (cmd_o[0] == CMD_REFRESH) ref_seen_a++;

      // Hand-computed schedule points.
      case (e)
         3: begin
            check("lit_rst_cke", 0, cke_o[0], 0);
            check("lit_rst_cmd", 0, cmd_o[0], 4'b0111);
            check("lit_rst_addr", 0, addr_o[0], 0);
            check("lit_rst_ba", 0, ba_o[0], 0);
            check("lit_rst_done", 0, done_o[0], 0);
            check("lit_rst_state", 0, st_dbg[0], ST_WAIT_PAA);
         end
         10: check("lit_cke_off", 0, cke_o[0], 0);
         11: check("lit_cke_on", 0, cke_o[0], 1);
         12: begin
            check("lit_prech", 0, cmd_o[0], 4'b0010);
            check("lit_prech_addr", 0, addr_o[0], 13'h0400);
         end
         15: check("lit_ref1", 0, cmd_o[0], 4'b0001);
         22: check("lit_b_prech", 1, cmd_o[1], 4'b0010);
         23: check("lit_b_ref1", 1, cmd_o[1], 4'b0001);
         24: begin
            check("lit_ref2", 0, cmd_o[0], 4'b0001);
            check("lit_b_ref2", 1, cmd_o[1], 4'b0001);
         end
         25: begin
            check("lit_b_lmr", 1, cmd_o[1], 4'b0000);
            check("lit_b_done_lo", 1, done_o[1], 0);
         end
         26: check("lit_b_done_hi", 1, done_o[1], 1);
         78: check("lit_ref8", 0, cmd_o[0], 4'b0001);
         87: begin
            check("lit_lmr", 0, cmd_o[0], 4'b0000);
            check("lit_lmr_addr", 0, addr_o[0], 13'h0033);
            check("lit_ref_count", 0, ref_seen_a, 8);
         end
         88: check("lit_done_lo", 0, done_o[0], 0);
         89: begin
            check("lit_done_hi", 0, done_o[0], 1);
            check("lit_done_state", 0, st_dbg[0], ST_DONE);
         end
         199: check("lit_mode_wait", 0, cmd_o[0], 4'b0111);
         200: check("lit_late_lmr", 0, cmd_o[0], 4'b0000);
         202: check("lit_late_done", 0, done_o[0], 1);
         248: begin
            check("lit_mid_rst_cke", 0, cke_o[0], 0);
            check("lit_mid_rst_cmd", 0, cmd_o[0], 4'b0111);
            check("lit_mid_rst_done", 0, done_o[0], 0);
         end
         326: begin
            check("lit_restart_lmr", 0, cmd_o[0], 4'b0000);
            check("lit_restart_refs", 0, ref_seen_a, 8);
         end
         328: check("lit_restart_done", 0, done_o[0], 1);
         422: check("lit_pulse_lmr", 0, cmd_o[0], 4'b0000);
         424: check("lit_pulse_done", 0, done_o[0], 1);
         460: begin
            check("lit_sticky_done", 0, done_o[0], 1);
            check("lit_sticky_nop", 0, cmd_o[0], 4'b0111);
         end
         default: ;
      endcase
   end

   initial begin
      rst_i = '{1'b1, 1'b1};
      paa_i = '{1'b0, 1'b0};
      set_i = '{1'b1, 1'b1};
      wait_edge(5);   rst_i[0] = 1'b0; rst_i[1] = 1'b0;
      wait_edge(9);   paa_i[0] = 1'b1;
      wait_edge(19);  paa_i[1] = 1'b1;
      // SET_MODE held low well past the last refresh gap.
      wait_edge(99);  rst_i[0] = 1'b1; paa_i[0] = 1'b0; set_i[0] = 1'b0;
      wait_edge(100); rst_i[0] = 1'b0;
      wait_edge(101); paa_i[0] = 1'b1;
      wait_edge(198); set_i[0] = 1'b1;
      // Reset during the 4th refresh wait, then restart with PAA still high.
      wait_edge(209); rst_i[0] = 1'b1; paa_i[0] = 1'b0;
      wait_edge(210); rst_i[0] = 1'b0;
      wait_edge(211); paa_i[0] = 1'b1;
      wait_edge(247); rst_i[0] = 1'b1;
      wait_edge(248); rst_i[0] = 1'b0;
      // Single-cycle PAA pulse, then input toggling after completion.
      wait_edge(339); rst_i[0] = 1'b1; paa_i[0] = 1'b0;
      wait_edge(340); rst_i[0] = 1'b0;
      wait_edge(344); paa_i[0] = 1'b1;
      wait_edge(345); paa_i[0] = 1'b0;
      for (int n = 430; n <= 460; n++) begin
         logic [31:0] nv;
         wait_edge(n);
         nv = n;
         paa_i[0] = nv[0]; set_i[0] = nv[1];
         paa_i[1] = nv[1]; set_i[1] = nv[0];
      end
      wait_edge(470);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", e);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/sdram_init_seq.md
Name: sdram_init_seq

Overview:
Consumes the power-up handshake (PAA, SET_MODE) from the SDRAM power-up wait stage and issues the JEDEC SDR init command sequence: CKE enable, PRECHARGE ALL, N x AUTO REFRESH, LOAD MODE REGISTER. It drives the command/address bus through the SDRAM controller's init mux. It raises INIT_DONE so the main controller takes over the bus.

Parameters:
ADDR_W, 13, SDRAM row/mode address width
BA_W, 2, bank address width
T_RP, 3, clocks from PRECHARGE issue to next command (>=1)
T_RFC, 9, clocks from AUTO REFRESH issue to next command (>=1)
T_MRD, 2, clocks from LOAD MODE issue to INIT_DONE (>=1)
REF_NUM, 8, number of AUTO REFRESH commands (1..255)
MODE_REG, 13'h0033, value driven on ADDR during LOAD MODE (burst 8, sequential, CL3)

Ports:
sdram_clk  in  1  controller clock
sdram_rst  in  1  synchronous reset, active-high
PAA  in  1  power-up wait complete (level)
SET_MODE  in  1  mode-register load permitted (level)
CKE  out  1  SDRAM clock enable
CMD  out  4  {CS_n,RAS_n,CAS_n,WE_n}
ADDR  out  ADDR_W  SDRAM address
BA  out  BA_W  bank address
INIT_DONE  out  1  sequence complete, sticky

Behaviour:
- Interface: one clock sdram_clk; reset sdram_rst is synchronous and active-high.
- All outputs registered. Reset values: CKE=0, CMD=NOP (4'b0111), ADDR=0, BA=0, INIT_DONE=0, state=WAIT_PAA, counters=0.
- Encodings: NOP 0111, PRECHARGE 0010, AUTO REFRESH 0001, LOAD MODE 0000.
- Every command is a 1-cycle pulse; CMD=NOP in all other cycles.
- FSM:
  - WAIT_PAA: CKE=0. On PAA=1, go to CKE_ON.
  - CKE_ON: CKE=1 (stays 1 until reset); 1 cycle; go to PRECH.
  - PRECH: CMD=PRECHARGE, ADDR[10]=1, other ADDR bits 0, BA=0; load timer=T_RP-1; go to WAIT_RP.
  - WAIT_RP: NOP until timer==0; then go to REF.
  - REF: CMD=AUTO REFRESH; increment ref_cnt; load timer=T_RFC-1; go to WAIT_RFC.
  - WAIT_RFC: NOP until timer==0; then go to REF if ref_cnt<REF_NUM, else go to WAIT_MODE.
  - WAIT_MODE: NOP while SET_MODE=0; on SET_MODE=1, go to LMR (a wait here does not violate timing).
  - LMR: CMD=LOAD MODE, ADDR=MODE_REG, BA=0; load timer=T_MRD-1; go to WAIT_MRD.
  - WAIT_MRD: NOP until timer==0; then go to DONE.
  - DONE: INIT_DONE=1; CMD=NOP; CKE=1; terminal until reset.
- Timer: down-counter, width clog2 of the largest T_x; a T_x=1 gives zero wait cycles (next command issues in the following cycle).
- ref_cnt: 8-bit; cleared at reset only.
- Spacing: command-to-command distance is exactly T_RP / T_RFC clocks.
- Cycle counts with SET_MODE=1 (PRECHARGE issue cycle to INIT_DONE rise): T_RP + REF_NUM*T_RFC + T_MRD.
- Latency: PAA sampled high at edge k gives CKE=1 after edge k+1 and PRECHARGE on CMD after edge k+2.
- PAA deassert after leaving WAIT_PAA: ignored.
- SET_MODE toggling outside WAIT_MODE: ignored.
- Reset mid-sequence: returns to WAIT_PAA with CKE=0 and CMD=NOP on the next edge; the full sequence restarts.
- ADDR/BA hold their last value during NOPs; the memory ignores them.

Decomposition:
- Shared package sdram_pkg holds:
  - the 4-bit command encodings (CMD_NOP, CMD_PRECHARGE, CMD_REFRESH, CMD_LMR, plus CMD_ACTIVE/READ/WRITE for the main controller);
  - the state enum;
  - the A10 precharge-all bit index.
- One natural sub-module, sdram_wait_timer: loadable down-counter with a zero flag, reused later by the main controller for tRCD/tWR.

Test Plan:
- Defaults, PAA rises at cycle 10, SET_MODE=1 -> CKE=1 at 11, PRECHARGE (ADDR[10]=1) at 12, REFRESH at 15,24,...,78, LOAD MODE ADDR=0x033 at 87, INIT_DONE at 89.
- SET_MODE held 0 until 20 cycles after the last refresh gap -> FSM stays in WAIT_MODE with NOP; LOAD MODE issues 1 cycle after SET_MODE rises; INIT_DONE follows T_MRD later.
- T_RP=T_RFC=T_MRD=1, REF_NUM=2 -> back-to-back PRECHARGE, REF, REF, LMR on consecutive cycles; INIT_DONE 1 cycle after LMR.
- sdram_rst asserted during the 4th refresh wait -> next edge CKE=0, CMD=NOP, INIT_DONE=0; after release plus PAA, exactly REF_NUM refreshes are counted again.
- PAA pulsed high 1 cycle then low -> the full sequence still completes; after INIT_DONE, toggling PAA/SET_MODE produces no further commands.
- Monitor check throughout: CMD never shows a non-NOP value for 2 consecutive cycles except when all T_x=1.
